// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Packet-granular arbiter that lets NUM_REQ byte-stream producers share one
// UART transmitter. A requester is granted in IDLE, then keeps the grant
// until the byte flagged "last" has left the transmitter. Bytes are paced
// on the transmitter busy flag. An owner that stops presenting bytes inside
// a packet is dropped after TIMEOUT_CYC idle cycles.
//
// Optional build macro:
//   UART_ARB_FIXED_PRIO_EN - lowest requester index always wins arbitration
//                            (round-robin pointer ignored). Undefined by
//                            default, giving round-robin arbitration.
//
// Ports:
//   i_clk_sys    system clock
//   i_rst        asynchronous, active-high reset
//   i_req_valid  per-requester byte valid
//   i_req_data   flattened bytes, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_req_last   per-requester "last byte of packet" flag
//   o_req_ready  per-requester byte accept (only the owner, only in SEND)
//   o_grant      one-hot current owner, 0 when idle
//   o_tx_start   one-cycle start pulse to the transmitter
//   o_tx_data    byte to the transmitter, valid with o_tx_start
//   i_tx_busy    transmitter is shifting a frame
//   o_timeout    one-cycle pulse when an owner is forcibly released
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_tx_start,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    input  logic                          i_tx_busy,
    output logic                          o_timeout
);

    localparam int              IDX_W   = $clog2(NUM_REQ);
    localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     TO_MAX  = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic             last_q;
    logic [15:0]      idle_cnt;
    logic             busy_wait;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_valid;
    logic             accept;
    logic             expire;

    assign owner_valid = i_req_valid[owner];

    // Acceptance is gated by busy so a start pulse is never issued onto a
    // transmitter that is still shifting.
    assign accept = (state == SEND) && owner_valid && !i_tx_busy;

    // The owner's last permitted idle cycle: the counter would reach
    // TIMEOUT_CYC on this edge, so release instead of counting.
    assign expire = (state == SEND) && !owner_valid && (idle_cnt == TO_LAST);

    // NOTE: every signal written in a combinational block gets a default
    // before any conditional assignment; otherwise a latch is inferred.
    always_comb begin
        o_req_ready = '0;
        if (state == SEND) begin
            o_req_ready[owner] = !i_tx_busy;
        end
    end

    // Winner selection for the IDLE state.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        // Scan downwards so the lowest set index is the final assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
`else
        // Scan from the slot after the last owner, wrapping, first hit wins.
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_found && i_req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_timeout  <= 1'b0;
            last_q     <= 1'b0;
            idle_cnt   <= '0;
            busy_wait  <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        o_grant  <= NUM_REQ'(1) << pick_idx;
                        idle_cnt <= '0;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (accept) begin
                        o_tx_data  <= i_req_data[owner*DATA_WIDTH +: DATA_WIDTH];
                        o_tx_start <= 1'b1;
                        last_q     <= i_req_last[owner];
                        idle_cnt   <= '0;
                        busy_wait  <= 1'b0;
                        state      <= WAIT_BUSY;
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        rr_ptr    <= owner;
                        idle_cnt  <= TO_MAX;
                        state     <= IDLE;
                    end else if (!owner_valid) begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end

                // Wait for the transmitter to acknowledge the start; give up
                // after two quiet cycles so a core that never raises busy
                // cannot hang the arbiter.
                WAIT_BUSY: begin
                    if (i_tx_busy || busy_wait) begin
                        state <= WAIT_DONE;
                    end else begin
                        busy_wait <= 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_q) begin
                            rr_ptr  <= owner;
                            o_grant <= '0;
                            state   <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// TIMEOUT_CYC=8). Requesters are byte queues, the transmitter is a model
// that holds busy for busy_len cycles after each start pulse. A table of
// arbitration vectors is followed by hand-written packet sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 8;
`ifdef UART_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_busy;
    logic              timeout;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_grant     (grant),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy),
        .o_timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bench state
    int            n_checks;
    int            n_fail;
    int            cyc;
    logic [DW:0]   qmem [NR][16];
    int            qhead [NR];
    int            qtail [NR];
    logic          en [NR];
    logic [NR-1:0] fire;
    int            busy_len;
    int            busy_cnt;
    logic          busy_seen;
    logic          have_start;
    logic          prev_busy;
    int            fall_cyc;
    int            timeout_seen;
    logic [NR-1:0] log_grant [64];
    logic [DW-1:0] log_data [64];
    int            log_cyc [64];
    int            log_n;

    typedef struct {
        int         prev;
        logic [3:0] mask;
        logic [3:0] exp_rr;
        logic [3:0] exp_fix;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [DW-1:0] d, input logic l);
        qmem[k][qtail[k]] = {l, d};
        qtail[k]++;
    endtask

    // Present queue heads to the DUT, then note which bytes will transfer
    // on the coming edge.
    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (en[k] && qhead[k] < qtail[k]) begin
                req_valid[k]          = 1'b1;
                req_data[k*DW +: DW]  = qmem[k][qhead[k]][DW-1:0];
                req_last[k]           = qmem[k][qhead[k]][DW];
            end else begin
                req_valid[k]          = 1'b0;
                req_data[k*DW +: DW]  = '0;
                req_last[k]           = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < NR; k++) begin
            fire[k] = req_valid[k] && req_ready[k];
        end
    endtask

    // One clock: retire accepted bytes, run the transmitter model, redrive.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NR; k++) begin
            if (fire[k]) qhead[k]++;
        end
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start) begin
            if (have_start) check("busy_between_starts", 32'(busy_seen), 32'd1);
            have_start = 1'b1;
            busy_seen  = 1'b0;
            if (log_n < 64) begin
                log_grant[log_n] = grant;
                log_data[log_n]  = tx_data;
                log_cyc[log_n]   = cyc;
                log_n++;
            end
            busy_cnt = busy_len;
        end
        tx_busy = (busy_cnt > 0);
        if (tx_busy) busy_seen = 1'b1;
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        if (timeout) timeout_seen++;
        drive();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        busy_len     = 0;
        busy_cnt     = 0;
        tx_busy      = 1'b0;
        busy_seen    = 1'b0;
        have_start   = 1'b0;
        prev_busy    = 1'b0;
        fall_cyc     = -1;
        timeout_seen = 0;
        log_n        = 0;
        fire         = '0;
        for (int k = 0; k < NR; k++) begin
            qhead[k] = 0;
            qtail[k] = 0;
            en[k]    = 1'b1;
        end
        drive();
        step();
        step();
        rst = 1'b0;
    endtask

    // Run until a grant has been seen and then dropped again.
    task automatic run_to_idle(input string name, input int budget);
        logic seen;
        logic done;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (grant != '0) seen = 1'b1;
            else if (seen)   done = 1'b1;
        end
        check({name, "_reached_idle"}, 32'(done), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;

        vecs[0] = '{-1, 4'b0110, 4'b0010, 4'b0010};
        vecs[1] = '{-1, 4'b1000, 4'b1000, 4'b1000};
        vecs[2] = '{ 0, 4'b0101, 4'b0100, 4'b0001};
        vecs[3] = '{ 1, 4'b0011, 4'b0001, 4'b0001};
        vecs[4] = '{ 2, 4'b1011, 4'b1000, 4'b0001};
        vecs[5] = '{ 3, 4'b1110, 4'b0010, 4'b0010};
        vecs[6] = '{ 3, 4'b1001, 4'b0001, 4'b0001};
        vecs[7] = '{ 1, 4'b0010, 4'b0010, 4'b0010};
        vecs[8] = '{ 2, 4'b0111, 4'b0001, 4'b0001};
        vecs[9] = '{ 0, 4'b1001, 4'b1000, 4'b0001};

        // Reset state
        #1;
        check("rst_grant",    32'(grant),     32'd0);
        check("rst_ready",    32'(req_ready), 32'd0);
        check("rst_tx_start", 32'(tx_start),  32'd0);
        check("rst_tx_data",  32'(tx_data),   32'd0);
        check("rst_timeout",  32'(timeout),   32'd0);

        // Arbitration vectors: optional prior packet sets the pointer
        for (int v = 0; v < 10; v++) begin
            do_reset();
            busy_len = 3;
            if (vecs[v].prev >= 0) begin
                push(vecs[v].prev, 8'h90, 1'b1);
                run_to_idle($sformatf("vec%0d_prev", v), 60);
            end
            for (int k = 0; k < NR; k++) begin
                if (vecs[v].mask[k]) push(k, 8'(8'h40 + k), 1'b1);
            end
            step();
            check($sformatf("vec%0d_no_ready_in_idle", v), 32'(req_ready), 32'd0);
            step();
            check($sformatf("vec%0d_grant", v), 32'(grant),
                  32'(FIXED ? vecs[v].exp_fix : vecs[v].exp_rr));
        end

        // Single requester, 3-byte packet, busy 10 cycles per byte
        begin
            int c0;
            int drop_cyc;
            logic seen;
            do_reset();
            busy_len = 10;
            push(1, 8'h11, 1'b0);
            push(1, 8'h22, 1'b0);
            push(1, 8'h33, 1'b1);
            step();
            c0       = cyc;
            drop_cyc = -1;
            seen     = 1'b0;
            for (int i = 0; i < 200 && drop_cyc < 0; i++) begin
                step();
                if (grant != '0) seen = 1'b1;
                else if (seen)   drop_cyc = cyc;
            end
            check("t1_starts",      32'(log_n),        32'd3);
            check("t1_latency",     32'(log_cyc[0]),   32'(c0 + 2));
            check("t1_byte0",       32'(log_data[0]),  32'h11);
            check("t1_byte1",       32'(log_data[1]),  32'h22);
            check("t1_byte2",       32'(log_data[2]),  32'h33);
            check("t1_owner",       32'(log_grant[2]), 32'b0010);
            check("t1_grant_drop",  32'(drop_cyc),     32'(fall_cyc + 1));
            check("t1_no_timeout",  32'(timeout_seen), 32'd0);
        end

        // Req0 and req2 valid from reset, 1-byte packets repeated
        do_reset();
        busy_len = 4;
        for (int i = 0; i < 3; i++) begin
            push(0, 8'(8'hA0 + i), 1'b1);
            push(2, 8'(8'hC0 + i), 1'b1);
        end
        for (int i = 0; i < 300 && !(log_n == 6 && grant == '0); i++) step();
        check("t2_starts", 32'(log_n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_grant%0d", i), 32'(log_grant[i]),
                  FIXED ? ((i < 3) ? 32'b0001 : 32'b0100)
                        : ((i % 2 == 0) ? 32'b0001 : 32'b0100));
        end

        // Req0 4-byte packet; req1 raises valid after byte 1 is accepted
        do_reset();
        busy_len = 3;
        push(0, 8'hB0, 1'b0);
        push(0, 8'hB1, 1'b0);
        push(0, 8'hB2, 1'b0);
        push(0, 8'hB3, 1'b1);
        push(1, 8'hE1, 1'b1);
        en[1] = 1'b0;
        for (int i = 0; i < 300 && !(log_n == 5 && grant == '0); i++) begin
            step();
            if (qhead[0] >= 1) en[1] = 1'b1;
        end
        check("t3_starts", 32'(log_n), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_lock%0d", i), {log_grant[i], log_data[i]},
                  {4'b0001, 8'(8'hB0 + i)});
        end
        check("t3_next_owner", {log_grant[4], log_data[4]}, {4'b0010, 8'hE1});

        // Timeout: req3 sends one non-last byte, then goes quiet
        begin
            int n;
            do_reset();
            busy_len = 3;
            push(3, 8'h5A, 1'b0);
            for (int i = 0; i < 50 && qhead[3] < 1; i++) step();
            check("t4_byte_sent", 32'(qhead[3]), 32'd1);
            for (int i = 0; i < 50 && !req_ready[3]; i++) step();
            check("t4_send_reentered", 32'(req_ready[3]), 32'd1);
            n = 0;
            for (int i = 0; i < 20 && !timeout; i++) begin
                step();
                n++;
            end
            check("t4_timeout_delay", 32'(n),     32'(TO));
            check("t4_grant_cleared", 32'(grant), 32'd0);
            // A valid appearing alongside the pulse must not be accepted
            push(3, 8'h6B, 1'b1);
            push(0, 8'h0C, 1'b1);
            drive();
            check("t4_no_rescue", 32'(req_ready), 32'd0);
            step();
            check("t4_pulse_width", 32'(timeout), 32'd0);
            check("t4_next_winner", 32'(grant),   32'b0001);
        end

        // Asynchronous reset mid-packet
        do_reset();
        busy_len = 6;
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b0);
        push(2, 8'hC3, 1'b1);
        for (int i = 0; i < 50 && log_n < 1; i++) step();
        check("t5_mid_packet", 32'(grant), 32'b0100);
        #2;
        rst  = 1'b1;
        fire = '0;
        for (int k = 0; k < NR; k++) begin
            qhead[k] = 0;
            qtail[k] = 0;
        end
        #1;
        check("t5_async_grant",   32'(grant),     32'd0);
        check("t5_async_ready",   32'(req_ready), 32'd0);
        check("t5_async_start",   32'(tx_start),  32'd0);
        check("t5_async_data",    32'(tx_data),   32'd0);
        check("t5_async_timeout", 32'(timeout),   32'd0);
        step();
        rst = 1'b0;
        push(1, 8'hD1, 1'b1);
        push(0, 8'hD0, 1'b1);
        step();
        step();
        check("t5_first_after_reset", 32'(grant), 32'b0001);

        // Req0 and req1 streaming 1-byte packets
        do_reset();
        busy_len = 2;
        for (int i = 0; i < 5; i++) begin
            push(0, 8'(8'h50 + i), 1'b1);
            push(1, 8'(8'h60 + i), 1'b1);
        end
        for (int i = 0; i < 400 && !(log_n == 10 && grant == '0); i++) step();
        check("t6_starts", 32'(log_n), 32'd10);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t6_grant%0d", i), 32'(log_grant[i]),
                  FIXED ? ((i < 5) ? 32'b0001 : 32'b0010)
                        : ((i % 2 == 0) ? 32'b0001 : 32'b0010));
        end

        // Transmitter that never raises busy: grant held exactly 4 cycles
        begin
            int held;
            do_reset();
            busy_len = 0;
            push(2, 8'h7E, 1'b1);
            held = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (grant != '0) held++;
            end
            check("t7_grant_cycles", 32'(held),  32'd4);
            check("t7_starts",       32'(log_n), 32'd1);
            check("t7_byte",         32'(log_data[0]), 32'h7E);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
